// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded grant length.
// State | meaning: IDLE | no owner, arbitrate on nonzero req; GRANT | one owner holds the resource.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] hcnt;

    logic [2:0] win;
    logic       win_found;
    logic [2:0] cand;
    logic       owner_req;
    logic       hold_exp;
    logic       release_now;

    // Circular scan starting just after the last owner.
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        cand      = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!win_found && req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    assign owner_req   = req[gnt_idx];
    assign hold_exp    = (hcnt == HOLD_LAST);
    assign release_now = done || !owner_req || hold_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            hcnt      <= 8'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    hcnt    <= 8'd0;
                    if (win_found) begin
                        state     <= GRANT;
                        gnt       <= 8'b1 << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        ptr       <= gnt_idx;
                        gnt       <= 8'h00;
                        gnt_idx   <= 3'd0;
                        gnt_valid <= 1'b0;
                        hcnt      <= 8'd0;
                        // Only a pure expiry counts; done or a dropped request wins a tie.
                        timeout   <= hold_exp && !done && owner_req;
                    end else begin
                        hcnt    <= hcnt + 8'd1;
                        timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: main instance with MAX_HOLD=4, second with MAX_HOLD=1.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;

    logic [7:0] gnt, gnt1;
    logic [2:0] gnt_idx, gnt_idx1;
    logic       gnt_valid, gnt_valid1;
    logic       timeout, timeout1;

    int vectors = 0;
    int miscompares = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    rr_arbiter8 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_valid(gnt_valid1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    // Packed expected output word {gnt, gnt_idx, gnt_valid, timeout}.
    function automatic logic [12:0] ex(input int idx, input bit v, input bit to);
        logic [7:0] g;
        logic [2:0] ix;
        g  = v ? (8'h01 << idx) : 8'h00;
        ix = v ? 3'(idx) : 3'd0;
        return {g, ix, v, to};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] got;
        rst_n = 1'b0; req = 8'h00; done = 1'b0;
        #12;
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 0, 0)) begin
            $display("FAIL reset_state got=%h want=%h", got, ex(0, 0, 0));
            miscompares++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_alternate();
        int seq[4] = '{0, 7, 0, 7};
        logic [12:0] got;
        req = 8'h81;
        foreach (seq[k]) begin
            tick();
            got = {gnt, gnt_idx, gnt_valid, timeout};
            vectors++;
            if (got !== ex(seq[k], 1, 0)) begin
                $display("FAIL alt_grant%0d got=%h want=%h", k, got, ex(seq[k], 1, 0));
                miscompares++;
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            got = {gnt, gnt_idx, gnt_valid, timeout};
            vectors++;
            if (got !== ex(0, 0, 0)) begin
                $display("FAIL alt_idle%0d got=%h want=%h", k, got, ex(0, 0, 0));
                miscompares++;
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [12:0] got;
        int w;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            w = k % 8;
            tick();
            got = {gnt, gnt_idx, gnt_valid, timeout};
            vectors++;
            if (got !== ex(w, 1, 0)) begin
                $display("FAIL rr_grant%0d got=%h want=%h", k, got, ex(w, 1, 0));
                miscompares++;
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            vectors++;
            if (gnt_valid !== 1'b0) begin
                $display("FAIL rr_gap%0d gnt_valid=%b want=0", k, gnt_valid);
                miscompares++;
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        logic [12:0] got;
        req = 8'h04;
        for (int k = 0; k < 4; k++) begin
            tick();
            got = {gnt, gnt_idx, gnt_valid, timeout};
            vectors++;
            if (got !== ex(2, 1, 0)) begin
                $display("FAIL to_hold%0d got=%h want=%h", k, got, ex(2, 1, 0));
                miscompares++;
            end
        end
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 0, 1)) begin
            $display("FAIL to_pulse got=%h want=%h", got, ex(0, 0, 1));
            miscompares++;
        end
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(2, 1, 0)) begin
            $display("FAIL to_regrant got=%h want=%h", got, ex(2, 1, 0));
            miscompares++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 8'h00;
        tick();
    endtask

    task automatic test_req_drop();
        logic [12:0] got;
        req = 8'h20;
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(5, 1, 0)) begin
            $display("FAIL drop_grant got=%h want=%h", got, ex(5, 1, 0));
            miscompares++;
        end
        req = 8'h01;
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 0, 0)) begin
            $display("FAIL drop_release got=%h want=%h", got, ex(0, 0, 0));
            miscompares++;
        end
        req = 8'h21;
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 1, 0)) begin
            $display("FAIL drop_next got=%h want=%h", got, ex(0, 1, 0));
            miscompares++;
        end
        req = 8'h23;
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 1, 0)) begin
            $display("FAIL other_req_ignored got=%h want=%h", got, ex(0, 1, 0));
            miscompares++;
        end
        done = 1'b1;
        req = 8'h00;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_done_timeout();
        logic [12:0] got;
        req = 8'h08;
        for (int k = 0; k < 4; k++) begin
            tick();
            got = {gnt, gnt_idx, gnt_valid, timeout};
            vectors++;
            if (got !== ex(3, 1, 0)) begin
                $display("FAIL tie_hold%0d got=%h want=%h", k, got, ex(3, 1, 0));
                miscompares++;
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 0, 0)) begin
            $display("FAIL tie_release got=%h want=%h", got, ex(0, 0, 0));
            miscompares++;
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_async_reset();
        logic [12:0] got;
        req = 8'h10;
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(4, 1, 0)) begin
            $display("FAIL ar_grant got=%h want=%h", got, ex(4, 1, 0));
            miscompares++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(0, 0, 0)) begin
            $display("FAIL ar_drop got=%h want=%h", got, ex(0, 0, 0));
            miscompares++;
        end
        req = 8'h80;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(7, 1, 0)) begin
            $display("FAIL ar_first got=%h want=%h", got, ex(7, 1, 0));
            miscompares++;
        end
        req = 8'h00;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic test_max_hold1();
        logic [12:0] got;
        rst_n = 1'b0;
        req = 8'h02;
        done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        got = {gnt1, gnt_idx1, gnt_valid1, timeout1};
        vectors++;
        if (got !== ex(1, 1, 0)) begin
            $display("FAIL mh1_grant got=%h want=%h", got, ex(1, 1, 0));
            miscompares++;
        end
        tick();
        got = {gnt1, gnt_idx1, gnt_valid1, timeout1};
        vectors++;
        if (got !== ex(0, 0, 1)) begin
            $display("FAIL mh1_release got=%h want=%h", got, ex(0, 0, 1));
            miscompares++;
        end
        got = {gnt, gnt_idx, gnt_valid, timeout};
        vectors++;
        if (got !== ex(1, 1, 0)) begin
            $display("FAIL mh4_still got=%h want=%h", got, ex(1, 1, 0));
            miscompares++;
        end
        tick();
        got = {gnt1, gnt_idx1, gnt_valid1, timeout1};
        vectors++;
        if (got !== ex(1, 1, 0)) begin
            $display("FAIL mh1_regrant got=%h want=%h", got, ex(1, 1, 0));
            miscompares++;
        end
        req = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alternate();
        test_round_robin();
        test_timeout();
        test_req_drop();
        test_done_timeout();
        test_async_reset();
        test_max_hold1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
